// File: rtl/serial_port_arbiter.sv
// Shares one serial TX/RX FIFO pair between NUM_REQ requesters.
// The write and read paths each have their own round-robin arbiter and sequencer.
module serial_port_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          tx_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   tx_data,
  output logic [NUM_REQ-1:0]          tx_ready,
  input  logic [NUM_REQ-1:0]          rx_req,
  output logic [NUM_REQ-1:0]          rx_valid,
  output logic [DATA_W-1:0]           rx_data,
  output logic [DATA_W-1:0]           SerialData_out,
  output logic                        SerialWrite,
  input  logic                        SerialFull,
  input  logic [DATA_W-1:0]           SerialData_in,
  output logic                        SerialRead,
  input  logic                        SerialEmpty,
  output logic [1:0]                  tx_state_dbg,
  output logic [1:0]                  rx_state_dbg
);

  // Handshake: a TX byte moves on a rising edge where tx_valid[i] and tx_ready[i]
  // are both high, and the requester holds tx_valid/tx_data stable until then.
  // rx_req is a level request; every rx_valid pulse hands over exactly one byte.

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_GRANT = 2'd1, TX_GAP = 2'd2} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_WAIT = 2'd1, RX_DONE = 2'd2} rx_state_e;

  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] win;
    logic             found;
    int               idx;
    win   = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IDX_W'(idx);
      end
    end
    return win;
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] owner);
    if (owner == IDX_W'(NUM_REQ - 1)) return '0;
    return owner + IDX_W'(1);
  endfunction

  // ---------------- write path ----------------
  tx_state_e          tx_state_q, tx_state_d;
  logic [IDX_W-1:0]   tx_owner_q, tx_owner_d;
  logic [IDX_W-1:0]   tx_ptr_q,   tx_ptr_d;
  logic [CNT_W-1:0]   tx_cnt_q,   tx_cnt_d;
  logic [DATA_W-1:0]  dout_q,     dout_d;
  logic               swrite_q,   swrite_d;
  logic               owner_valid;
  logic [DATA_W-1:0]  owner_data;

  assign owner_valid = tx_valid[tx_owner_q];
  assign owner_data  = tx_data[tx_owner_q*DATA_W +: DATA_W];

  always_comb begin
    tx_state_d = tx_state_q;
    tx_owner_d = tx_owner_q;
    tx_ptr_d   = tx_ptr_q;
    tx_cnt_d   = tx_cnt_q;
    dout_d     = dout_q;
    swrite_d   = 1'b0;
    tx_ready   = '0;
    case (tx_state_q)
      TX_IDLE: begin
        if (|tx_valid) begin
          tx_owner_d = rr_pick(tx_valid, tx_ptr_q);
          tx_cnt_d   = '0;
          tx_state_d = TX_GRANT;
        end
      end
      TX_GRANT: begin
        if (!owner_valid) begin
          tx_ptr_d   = next_ptr(tx_owner_q);
          tx_state_d = TX_IDLE;
        end else if (!SerialFull) begin
          tx_ready[tx_owner_q] = 1'b1;
          dout_d     = owner_data;
          swrite_d   = 1'b1;
          tx_cnt_d   = tx_cnt_q + CNT_W'(1);
          tx_state_d = TX_GAP;
        end
      end
      TX_GAP: begin
        // The gap cycle lets SerialFull catch up with the write just issued.
        if ((tx_cnt_q == CNT_W'(MAX_BURST)) || !owner_valid) begin
          tx_ptr_d   = next_ptr(tx_owner_q);
          tx_state_d = TX_IDLE;
        end else begin
          tx_state_d = TX_GRANT;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q <= TX_IDLE;
      tx_owner_q <= '0;
      tx_ptr_q   <= '0;
      tx_cnt_q   <= '0;
      dout_q     <= '0;
      swrite_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_owner_q <= tx_owner_d;
      tx_ptr_q   <= tx_ptr_d;
      tx_cnt_q   <= tx_cnt_d;
      dout_q     <= dout_d;
      swrite_q   <= swrite_d;
    end
  end

  // ---------------- read path ----------------
  rx_state_e          rx_state_q, rx_state_d;
  logic [IDX_W-1:0]   rx_owner_q, rx_owner_d;
  logic [IDX_W-1:0]   rx_ptr_q,   rx_ptr_d;
  logic               sread_q,    sread_d;
  logic [NUM_REQ-1:0] rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0]  rx_data_q,  rx_data_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_owner_d = rx_owner_q;
    rx_ptr_d   = rx_ptr_q;
    sread_d    = 1'b0;
    rx_valid_d = '0;
    rx_data_d  = rx_data_q;
    case (rx_state_q)
      RX_IDLE: begin
        if ((|rx_req) && !SerialEmpty) begin
          rx_owner_d = rr_pick(rx_req, rx_ptr_q);
          sread_d    = 1'b1;
          rx_state_d = RX_WAIT;
        end
      end
      RX_WAIT: rx_state_d = RX_DONE;
      RX_DONE: begin
        // Delivered even if the owner dropped rx_req after the pop.
        rx_data_d             = SerialData_in;
        rx_valid_d[rx_owner_q] = 1'b1;
        rx_ptr_d              = next_ptr(rx_owner_q);
        rx_state_d            = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q <= RX_IDLE;
      rx_owner_q <= '0;
      rx_ptr_q   <= '0;
      sread_q    <= 1'b0;
      rx_valid_q <= '0;
      rx_data_q  <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_owner_q <= rx_owner_d;
      rx_ptr_q   <= rx_ptr_d;
      sread_q    <= sread_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign SerialData_out = dout_q;
  assign SerialWrite    = swrite_q;
  assign SerialRead     = sread_q;
  assign rx_valid       = rx_valid_q;
  assign rx_data        = rx_data_q;
  assign tx_state_dbg   = tx_state_q;
  assign rx_state_dbg   = rx_state_q;

endmodule

// File: tb/tb_serial_port_arbiter.sv
// Bench for serial_port_arbiter: directed and randomized traffic checked against a
// transaction-level round-robin / burst model of both paths.
module tb_serial_port_arbiter;
  localparam int NREQ = 3;
  localparam int DW   = 8;
  localparam int MB   = 4;
  localparam int MAXQ = 32;

  logic                 clock;
  logic                 reset_n;
  logic [NREQ-1:0]      tx_valid;
  logic [NREQ*DW-1:0]   tx_data;
  logic [NREQ-1:0]      tx_ready;
  logic [NREQ-1:0]      rx_req;
  logic [NREQ-1:0]      rx_valid;
  logic [DW-1:0]        rx_data;
  logic [DW-1:0]        SerialData_out;
  logic                 SerialWrite;
  logic                 SerialFull;
  logic [DW-1:0]        SerialData_in;
  logic                 SerialRead;
  logic                 SerialEmpty;
  logic [1:0]           tx_state_dbg;
  logic [1:0]           rx_state_dbg;

  serial_port_arbiter #(.NUM_REQ(NREQ), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clock(clock), .reset_n(reset_n),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_req(rx_req), .rx_valid(rx_valid), .rx_data(rx_data),
    .SerialData_out(SerialData_out), .SerialWrite(SerialWrite), .SerialFull(SerialFull),
    .SerialData_in(SerialData_in), .SerialRead(SerialRead), .SerialEmpty(SerialEmpty),
    .tx_state_dbg(tx_state_dbg), .rx_state_dbg(rx_state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec;
  int n_err;
  logic [DW-1:0] tx_buf [NREQ][MAXQ];
  int            tx_len [NREQ];
  int            tx_pos [NREQ];
  int            rx_want[NREQ];
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_tx_q[$];
  logic [DW-1:0] exp_rx_q[$];
  int            exp_own_q[$];
  int            m_tx_ptr;
  int            m_rx_ptr;
  bit            rx_hold;
  bit            saw_both;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_tx();
    for (int i = 0; i < NREQ; i++) begin
      if (tx_pos[i] < tx_len[i]) begin
        tx_valid[i]          = 1'b1;
        tx_data[i*DW +: DW]  = tx_buf[i][tx_pos[i]];
      end else begin
        tx_valid[i]          = 1'b0;
        tx_data[i*DW +: DW]  = '0;
      end
    end
  endtask

  task automatic drive_rx_req();
    for (int i = 0; i < NREQ; i++) rx_req[i] = (rx_want[i] > 0) && !rx_hold;
  endtask

  task automatic load_tx_rand(input int p, input int n);
    for (int k = 0; k < n; k++) tx_buf[p][k] = DW'($urandom_range(1, 255));
    tx_len[p] = n;
    tx_pos[p] = 0;
  endtask

  task automatic load_fifo_rand(input int n);
    for (int k = 0; k < n; k++) fifo_q.push_back(DW'($urandom_range(1, 255)));
  endtask

  task automatic clear_state();
    for (int i = 0; i < NREQ; i++) begin
      tx_len[i]  = 0;
      tx_pos[i]  = 0;
      rx_want[i] = 0;
    end
    fifo_q.delete();
    exp_tx_q.delete();
    exp_rx_q.delete();
    exp_own_q.delete();
    rx_hold = 1'b0;
    drive_tx();
    drive_rx_req();
    SerialFull  = 1'b0;
    SerialEmpty = 1'b1;
  endtask

  // ---------------- reference model ----------------
  // Write order: owner = first port at/after the pointer with bytes left; it sends
  // up to MB bytes, then the pointer moves past it.
  task automatic build_tx_model();
    int rem[NREQ];
    int pos[NREQ];
    int total, owner, sent, idx;
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = tx_len[i] - tx_pos[i];
      pos[i] = tx_pos[i];
    end
    while (1) begin
      total = 0;
      for (int i = 0; i < NREQ; i++) total += rem[i];
      if (total == 0) break;
      owner = -1;
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_tx_ptr + k) % NREQ;
        if (owner < 0 && rem[idx] > 0) owner = idx;
      end
      sent = 0;
      while (sent < MB && rem[owner] > 0) begin
        exp_tx_q.push_back(tx_buf[owner][pos[owner]]);
        pos[owner]++;
        rem[owner]--;
        sent++;
      end
      m_tx_ptr = (owner + 1) % NREQ;
    end
  endtask

  // Read order: one FIFO byte per grant to the next requesting port in RR order.
  task automatic build_rx_model();
    int w[NREQ];
    int owner, idx;
    for (int i = 0; i < NREQ; i++) w[i] = rx_want[i];
    for (int f = 0; f < fifo_q.size(); f++) begin
      owner = -1;
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_rx_ptr + k) % NREQ;
        if (owner < 0 && w[idx] > 0) owner = idx;
      end
      if (owner < 0) break;
      exp_own_q.push_back(owner);
      exp_rx_q.push_back(fifo_q[f]);
      w[owner]--;
      m_rx_ptr = (owner + 1) % NREQ;
    end
  endtask

  // ---------------- scoreboard / phase runner ----------------
  task automatic run_phase(input int max_cyc, input int full_hold, input bit full_rand,
                           input bit drop_mode);
    int cyc, tail, age, full_left, after_drop, own, remain;
    bit pend, pop_now;
    logic [NREQ-1:0] acc, prev_ready;
    logic [DW-1:0] e;
    build_tx_model();
    build_rx_model();
    full_left   = full_hold;
    SerialFull  = (full_left > 0);
    SerialEmpty = (fifo_q.size() == 0);
    rx_hold     = 1'b0;
    drive_tx();
    drive_rx_req();
    prev_ready = '0;
    pend = 1'b0; age = 0; after_drop = 0; cyc = 0; tail = 0;
    while (cyc < max_cyc && tail < 4) begin
      @(negedge clock);
      acc = tx_ready & tx_valid;
      check("tx_ready_onehot", 32'($countones(tx_ready) <= 1), 32'(1));
      check("tx_ready_without_valid", 32'(tx_ready & ~tx_valid), 32'(0));
      if (SerialFull) check("tx_ready_while_full", 32'(tx_ready), 32'(0));
      check("write_follows_accept", 32'(SerialWrite), 32'(|prev_ready));
      if (SerialWrite) begin
        if (exp_tx_q.size() == 0) check("tx_unexpected_write", 32'(SerialWrite), 32'(0));
        else begin
          e = exp_tx_q.pop_front();
          check("tx_byte", 32'(SerialData_out), 32'(e));
        end
      end
      if (after_drop == 2) begin
        check("write_after_full_drop", 32'(SerialWrite), 32'(1));
        after_drop = 0;
      end
      if (after_drop == 1) begin
        check("ready_after_full_drop", 32'(|tx_ready), 32'(1));
        after_drop = 2;
      end
      prev_ready = tx_ready;

      if (pend) age++;
      check("rx_valid_onehot", 32'($countones(rx_valid) <= 1), 32'(1));
      if (|rx_valid) begin
        if (exp_own_q.size() == 0) check("rx_unexpected_valid", 32'(rx_valid), 32'(0));
        else begin
          own = exp_own_q.pop_front();
          e   = exp_rx_q.pop_front();
          check("rx_owner", 32'(rx_valid), 32'(1) << own);
          check("rx_byte", 32'(rx_data), 32'(e));
          check("rx_latency", pend ? 32'(age) : 32'hFFFF_FFFF, 32'(2));
          if (rx_want[own] > 0) rx_want[own]--;
        end
        pend = 1'b0;
        rx_hold = 1'b0;
      end else if (pend && age >= 3) begin
        check("rx_missing_valid", 32'(|rx_valid), 32'(1));
        pend = 1'b0;
        rx_hold = 1'b0;
      end
      pop_now = 1'b0;
      if (SerialRead) begin
        check("read_when_empty", 32'(fifo_q.size() != 0), 32'(1));
        check("read_overlap", 32'(pend), 32'(0));
        pend = 1'b1;
        age = 0;
        pop_now = (fifo_q.size() != 0);
        if (drop_mode) rx_hold = 1'b1;
      end
      if (SerialWrite && SerialRead) saw_both = 1'b1;
      drive_rx_req();

      @(posedge clock);
      #1;
      for (int i = 0; i < NREQ; i++)
        if (acc[i] && tx_pos[i] < tx_len[i]) tx_pos[i]++;
      drive_tx();
      if (pop_now) begin
        SerialData_in = fifo_q.pop_front();
        SerialEmpty   = (fifo_q.size() == 0);
      end
      if (full_left > 0) begin
        full_left--;
        if (full_left == 0) after_drop = 1;
      end
      SerialFull = (full_left > 0) || (full_rand && $urandom_range(0, 2) == 0);
      cyc++;
      if (exp_tx_q.size() == 0 && exp_own_q.size() == 0 && !pend) tail++;
      else tail = 0;
    end
    remain = 0;
    for (int i = 0; i < NREQ; i++) remain += tx_len[i] - tx_pos[i];
    check("tx_all_accepted", 32'(remain), 32'(0));
    check("tx_all_written", 32'(exp_tx_q.size()), 32'(0));
    check("rx_all_delivered", 32'(exp_own_q.size()), 32'(0));
    SerialFull = 1'b0;
    for (int i = 0; i < NREQ; i++) rx_want[i] = 0;
    rx_hold = 1'b0;
    drive_rx_req();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tx_ready"},    32'(tx_ready),       32'(0));
    check({tag, "_rx_valid"},    32'(rx_valid),       32'(0));
    check({tag, "_rx_data"},     32'(rx_data),        32'(0));
    check({tag, "_data_out"},    32'(SerialData_out), 32'(0));
    check({tag, "_write"},       32'(SerialWrite),    32'(0));
    check({tag, "_read"},        32'(SerialRead),     32'(0));
    check({tag, "_tx_state"},    32'(tx_state_dbg),   32'(0));
    check({tag, "_rx_state"},    32'(rx_state_dbg),   32'(0));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit found;
    n_vec = 0;
    n_err = 0;
    m_tx_ptr = 0;
    m_rx_ptr = 0;
    saw_both = 1'b0;
    reset_n = 1'b0;
    tx_valid = '0;
    tx_data = '0;
    rx_req = '0;
    SerialFull = 1'b0;
    SerialData_in = '0;
    SerialEmpty = 1'b1;
    clear_state();
    @(negedge clock);
    check_outputs_zero("reset");
    @(negedge clock);
    reset_n = 1'b1;

    // Two single-byte requesters alternate: A5 then 3C.
    clear_state();
    tx_buf[0][0] = 8'hA5; tx_len[0] = 1;
    tx_buf[1][0] = 8'h3C; tx_len[1] = 1;
    run_phase(100, 0, 1'b0, 1'b0);

    // Long port-0 stream against port 1: bursts capped at MB.
    clear_state();
    load_tx_rand(0, 10);
    load_tx_rand(1, 5);
    run_phase(200, 0, 1'b0, 1'b0);

    // FIFO full held across the grant, then released.
    clear_state();
    load_tx_rand(1, 2);
    run_phase(100, 6, 1'b0, 1'b0);

    // Two readers share 11, 22; port 2 keeps requesting into an empty FIFO.
    clear_state();
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    rx_want[0] = 1; rx_want[1] = 1; rx_want[2] = 1;
    run_phase(100, 0, 1'b0, 1'b0);

    // Requester withdraws rx_req once its read is under way.
    clear_state();
    load_fifo_rand(2);
    rx_want[1] = 2;
    run_phase(100, 0, 1'b0, 1'b1);

    // Both paths busy together.
    clear_state();
    load_tx_rand(2, 3);
    load_tx_rand(0, 2);
    load_fifo_rand(3);
    rx_want[0] = 1; rx_want[1] = 1; rx_want[2] = 1;
    saw_both = 1'b0;
    run_phase(200, 0, 1'b0, 1'b0);
    check("tx_rx_same_cycle", 32'(saw_both), 32'(1));

    for (int r = 0; r < 8; r++) begin
      clear_state();
      for (int i = 0; i < NREQ; i++) begin
        load_tx_rand(i, $urandom_range(0, 8));
        rx_want[i] = $urandom_range(0, 3);
      end
      load_fifo_rand($urandom_range(0, 6));
      run_phase(400, 0, 1'b1, 1'($urandom_range(0, 1)));
    end

    // Reset while a write strobe is out.
    clear_state();
    load_tx_rand(0, 4);
    load_fifo_rand(1);
    rx_want[0] = 1;
    SerialEmpty = 1'b0;
    drive_tx();
    drive_rx_req();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clock);
      if (SerialWrite) found = 1'b1;
    end
    check("reset_setup_write_seen", 32'(SerialWrite), 32'(1));
    reset_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    clear_state();
    m_tx_ptr = 0;
    m_rx_ptr = 0;
    @(negedge clock);
    check_outputs_zero("held_reset");
    reset_n = 1'b1;

    // Traffic after reset starts from pointer 0.
    clear_state();
    for (int i = 0; i < NREQ; i++) begin
      load_tx_rand(i, $urandom_range(1, 6));
      rx_want[i] = $urandom_range(1, 2);
    end
    load_fifo_rand(5);
    run_phase(400, 0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
